// File: rtl/gemm_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : gemm_result_collector
// Summary  : Gathers INPUT_SIZE systolic-array result rows into one matrix.
//            Two ping-pong banks let the consumer stall; rows that arrive
//            with both banks full are dropped and flagged in a sticky bit.
//            Optional flush input when GEMM_COLLECTOR_FLUSH_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module gemm_result_collector #(
  parameter int SA_SIZE                = 4,
  parameter int INPUT_SIZE             = 2,
  parameter int WEIGHT_ACTIVATION_SIZE = 8
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic                                                 in_valid,
  input  logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0]            in_data,
  output logic                                                 m_valid,
  input  logic                                                 m_ready,
  output logic [INPUT_SIZE*SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] m_data,
  output logic                                                 overflow,
  input  logic                                                 overflow_clear
`ifdef GEMM_COLLECTOR_FLUSH_EN
  ,
  input  logic                                                 flush
`endif
);

  localparam int C_ROW_W = SA_SIZE * WEIGHT_ACTIVATION_SIZE;
  localparam int C_MAT_W = INPUT_SIZE * C_ROW_W;
  localparam int C_CNT_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST_ROW = C_CNT_W'(INPUT_SIZE - 1);

  logic [C_MAT_W-1:0] bank_q [2];
  logic [C_MAT_W-1:0] bank_d [2];
  logic [1:0]         full_q, full_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [C_CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic               overflow_q, overflow_d;

  logic               wr_en;
  logic               wr_last;
`ifdef GEMM_COLLECTOR_FLUSH_EN
  int                 fill_start;
`endif

  always_comb begin
    bank_d     = bank_q;
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    row_cnt_d  = row_cnt_q;
    overflow_d = overflow_q;

    // Both paths look at the pre-edge full flags, so a bank released this
    // cycle cannot accept a row until the next one.
    wr_en   = in_valid && !full_q[wr_bank_q];
    wr_last = (row_cnt_q == C_LAST_ROW);

    if (full_q[rd_bank_q] && m_ready) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end

    if (overflow_clear) begin
      overflow_d = 1'b0;
    end
    if (in_valid && full_q[wr_bank_q]) begin
      overflow_d = 1'b1;
    end

    if (wr_en) begin
      bank_d[wr_bank_q][int'(row_cnt_q)*C_ROW_W +: C_ROW_W] = in_data;
      if (wr_last) begin
        row_cnt_d         = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        row_cnt_d = row_cnt_q + 1'b1;
      end
    end

`ifdef GEMM_COLLECTOR_FLUSH_EN
    // A row arriving with the flush lands first; the rest is zero-filled.
    fill_start = int'(row_cnt_q) + (wr_en ? 1 : 0);
    if (flush && (row_cnt_q != '0) && !full_q[wr_bank_q] && !(wr_en && wr_last)) begin
      for (int r = 0; r < INPUT_SIZE; r++) begin
        if (r >= fill_start) begin
          bank_d[wr_bank_q][r*C_ROW_W +: C_ROW_W] = '0;
        end
      end
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
      row_cnt_d         = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q[0]  <= '0;
      bank_q[1]  <= '0;
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      row_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      bank_q[0]  <= bank_d[0];
      bank_q[1]  <= bank_d[1];
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      row_cnt_q  <= row_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign m_valid  = full_q[rd_bank_q];
  assign m_data   = bank_q[rd_bank_q];
  assign overflow = overflow_q;

endmodule
`default_nettype wire
